cond_resolve_unit: RTL and testbench
====================================

Name: cond_resolve_unit

Overview:
- Reader side of the NZVC condition-flag register. It evaluates conditional-branch and CBZ/CBNZ requests from the decode/branch stage against the architectural flags.
- Flags being written in the same cycle by a flag-setting ALU op in EX are forwarded, so the unit sees them one cycle before they land in the register.
- Ready/valid on both request and result, a wait state for flags still in flight, and saturating taken/mispredict counters for performance monitoring.

Parameters:
- CNT_W, 16: width of the saturating statistics counters.

Ports:
- clk  in  1  core clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-low reset (0 = reset asserted).
- negativeC  in  1  stored N flag (registered output of the flag register).
- zeroC  in  1  stored Z flag.
- overflowC  in  1  stored V flag.
- carry_outC  in  1  stored C flag.
- fwd_en  in  1  an EX-stage instruction writes the flags at this cycle's edge.
- fwd_n, fwd_z, fwd_v, fwd_c  in  1 each  flag values being written that cycle.
- flags_pending  in  1  an older flag-setter has not yet reached EX; the flags are not yet valid.
- req_valid  in  1  branch request valid.
- req_ready  out  1  unit can accept a request.
- req_cond  in  4  ARM condition code, 0..15.
- req_is_cbz  in  1  CBZ/CBNZ request; req_cond is ignored.
- req_cbnz  in  1  with req_is_cbz: 1 = CBNZ, 0 = CBZ.
- req_rt_zero  in  1  the tested register equals zero.
- req_pred  in  1  front-end prediction: 1 = taken.
- res_valid  out  1  result valid.
- res_ready  in  1  consumer accepts the result.
- res_taken  out  1  branch resolved taken.
- res_mispredict  out  1  res_taken differs from the captured req_pred.
- taken_cnt  out  CNT_W  count of taken results handed off, saturating.
- mispred_cnt  out  CNT_W  count of mispredicted results handed off, saturating.

Behaviour:
- Reset (reset==0 at an edge):
  - State goes to IDLE.
  - res_valid, res_taken and res_mispredict go to 0.
  - Both counters go to 0.
  - Any captured request is discarded.
  - Reset applies in every state, including mid-WAIT or mid-RESP.
- Flag selection (combinational): if fwd_en, use fwd_*; otherwise use the stored *C flags.
- Condition evaluation on the selected N,Z,V,C:
  - 0 EQ: Z. 1 NE: !Z.
  - 2 HS: C. 3 LO: !C.
  - 4 MI: N. 5 PL: !N.
  - 6 VS: V. 7 VC: !V.
  - 8 HI: C&!Z. 9 LS: !(C&!Z).
  - 10 GE: N==V. 11 LT: N!=V.
  - 12 GT: !Z&(N==V). 13 LE: its inverse.
  - 14 AL: 1. 15 NV: 1.
- CBZ/CBNZ: taken = req_rt_zero ^ req_cbnz. Flags and flags_pending are ignored.
- FSM states are IDLE, WAIT, RESP.
- IDLE:
  - req_ready=1.
  - On req_valid, capture cond, is_cbz, cbnz, rt_zero and pred.
  - If a flag-conditional request sees flags_pending=1, go to WAIT.
  - Otherwise evaluate this cycle, register res_taken and res_mispredict, and go to RESP. Latency: accept at edge N gives res_valid=1 after edge N.
- WAIT:
  - req_ready=0.
  - Each cycle with flags_pending=0, evaluate the captured request against the selected flags (forwarding applies) and go to RESP. Otherwise stay.
  - There is no timeout.
- RESP:
  - res_valid=1, req_ready=0.
  - res_taken and res_mispredict hold stable while res_ready=0.
  - On res_ready=1, go to IDLE at that edge.
  - No back-to-back accept in the handoff cycle; maximum throughput is 1 result per 2 cycles.
- Counters update only at the handoff edge (RESP with res_ready=1):
  - taken_cnt += res_taken.
  - mispred_cnt += res_mispredict.
  - Each counter saturates at all-ones and never wraps.
- Simultaneous fwd_en and flags_pending: flags_pending wins, so no evaluation happens that cycle.
- req_valid while req_ready=0 is ignored. The requester must hold the request.

Decomposition:
- Shared package holds:
  - the cond-code enum (COND_EQ..COND_NV, 4 bits);
  - the FSM state enum;
  - a packed nzvc_t struct.
- One sub-module, cond_eval: purely combinational (nzvc_t, cond) -> taken. It is reused by the other CBZ/B.cond users.

Test Plan:
- Stored Z=1, fwd_en=0, req cond=0 (EQ), pred=0 -> one cycle later res_valid=1, res_taken=1, res_mispredict=1; after res_ready, mispred_cnt=1, taken_cnt=1.
- Stored N=0,V=0,Z=0 with fwd_en=1, fwd_n=1, fwd_v=0, cond=11 (LT) -> taken=1, using forwarded flags, not stored.
- flags_pending=1 for 3 cycles, cond=12 (GT); pending then drops with N=V=1, Z=0 -> res_valid asserts 1 cycle after pending drops, taken=1; req_ready=0 throughout.
- CBNZ with rt_zero=1 while flags_pending=1 -> no WAIT, res_taken=0 next cycle; CBZ with rt_zero=1 -> taken=1.
- res_ready held 0 for 5 cycles -> res_valid and res_taken stable; req_valid pulses ignored; counters unchanged until handoff.
- Preload taken_cnt near saturation (CNT_W=4, 16 taken AL requests) -> taken_cnt sticks at 15; reset=0 mid-WAIT -> IDLE, res_valid=0, counters 0.

Source files
------------

// File: rtl/cond_resolve_unit_pkg.sv
// cond_resolve_unit_pkg: shared condition-code, FSM state and flag types.
package cond_resolve_unit_pkg;
  typedef enum logic [3:0] {
    COND_EQ, COND_NE, COND_HS, COND_LO, COND_MI, COND_PL, COND_VS, COND_VC,
    COND_HI, COND_LS, COND_GE, COND_LT, COND_GT, COND_LE, COND_AL, COND_NV
  } cond_e;
  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_e;
  typedef struct packed {
    logic n;
    logic z;
    logic v;
    logic c;
  } nzvc_t;
endpackage

// File: rtl/cond_resolve_unit_cond_eval.sv
// cond_eval: combinational ARM condition-code evaluation against NZVC flags.
module cond_eval
  import cond_resolve_unit_pkg::*;
(
  input  nzvc_t      flags_i,
  input  logic [3:0] cond_i,
  output logic       taken_o
);
  always_comb begin
    taken_o = 1'b1;
    case (cond_e'(cond_i))
      COND_EQ: taken_o = flags_i.z;
      COND_NE: taken_o = !flags_i.z;
      COND_HS: taken_o = flags_i.c;
      COND_LO: taken_o = !flags_i.c;
      COND_MI: taken_o = flags_i.n;
      COND_PL: taken_o = !flags_i.n;
      COND_VS: taken_o = flags_i.v;
      COND_VC: taken_o = !flags_i.v;
      COND_HI: taken_o = flags_i.c && !flags_i.z;
      COND_LS: taken_o = !(flags_i.c && !flags_i.z);
      COND_GE: taken_o = flags_i.n == flags_i.v;
      COND_LT: taken_o = flags_i.n != flags_i.v;
      COND_GT: taken_o = !flags_i.z && (flags_i.n == flags_i.v);
      COND_LE: taken_o = !(!flags_i.z && (flags_i.n == flags_i.v));
      default: taken_o = 1'b1;
    endcase
  end
endmodule

// File: rtl/cond_resolve_unit.sv
// cond_resolve_unit: resolves B.cond and CBZ/CBNZ requests against forwarded or stored NZVC flags.
module cond_resolve_unit
  import cond_resolve_unit_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             negativeC,
  input  logic             zeroC,
  input  logic             overflowC,
  input  logic             carry_outC,
  input  logic             fwd_en,
  input  logic             fwd_n,
  input  logic             fwd_z,
  input  logic             fwd_v,
  input  logic             fwd_c,
  input  logic             flags_pending,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [3:0]       req_cond,
  input  logic             req_is_cbz,
  input  logic             req_cbnz,
  input  logic             req_rt_zero,
  input  logic             req_pred,
  output logic             res_valid,
  input  logic             res_ready,
  output logic             res_taken,
  output logic             res_mispredict,
  output logic [CNT_W-1:0] taken_cnt,
  output logic [CNT_W-1:0] mispred_cnt
);
  state_e           state_q, state_d;
  logic [3:0]       cond_q, cond_d;
  logic             cbz_q, cbz_d, cbnz_q, cbnz_d, rtz_q, rtz_d, pred_q, pred_d;
  logic             taken_q, taken_d, mis_q, mis_d;
  logic [CNT_W-1:0] tcnt_q, tcnt_d, mcnt_q, mcnt_d;
  nzvc_t            flags;
  logic             idle, cond_taken, eval_taken, can_eval;
  logic [3:0]       cur_cond;
  logic             cur_cbz, cur_cbnz, cur_rtz, cur_pred;

  assign idle     = state_q == IDLE;
  // In IDLE the live request is evaluated; in WAIT the captured copy is.
  assign cur_cond = idle ? req_cond : cond_q;
  assign cur_cbz  = idle ? req_is_cbz : cbz_q;
  assign cur_cbnz = idle ? req_cbnz : cbnz_q;
  assign cur_rtz  = idle ? req_rt_zero : rtz_q;
  assign cur_pred = idle ? req_pred : pred_q;
  assign flags    = fwd_en ? {fwd_n, fwd_z, fwd_v, fwd_c} : {negativeC, zeroC, overflowC, carry_outC};

  cond_eval u_eval (.flags_i(flags), .cond_i(cur_cond), .taken_o(cond_taken));

  assign eval_taken = cur_cbz ? cur_rtz ^ cur_cbnz : cond_taken;
  assign can_eval   = cur_cbz || !flags_pending;

  always_comb begin
    state_d = state_q;
    cond_d  = cond_q;
    cbz_d   = cbz_q;
    cbnz_d  = cbnz_q;
    rtz_d   = rtz_q;
    pred_d  = pred_q;
    taken_d = taken_q;
    mis_d   = mis_q;
    tcnt_d  = tcnt_q;
    mcnt_d  = mcnt_q;
    case (state_q)
      IDLE: if (req_valid) begin
        cond_d  = req_cond;
        cbz_d   = req_is_cbz;
        cbnz_d  = req_cbnz;
        rtz_d   = req_rt_zero;
        pred_d  = req_pred;
        state_d = can_eval ? RESP : WAIT;
      end
      WAIT: if (can_eval) state_d = RESP;
      RESP: if (res_ready) begin
        state_d = IDLE;
        tcnt_d  = tcnt_q + CNT_W'(taken_q && !(&tcnt_q));
        mcnt_d  = mcnt_q + CNT_W'(mis_q && !(&mcnt_q));
      end
      default: state_d = IDLE;
    endcase
    if (((idle && req_valid) || state_q == WAIT) && can_eval) begin
      taken_d = eval_taken;
      mis_d   = eval_taken ^ cur_pred;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= IDLE;
      cond_q  <= '0;
      cbz_q   <= 1'b0;
      cbnz_q  <= 1'b0;
      rtz_q   <= 1'b0;
      pred_q  <= 1'b0;
      taken_q <= 1'b0;
      mis_q   <= 1'b0;
      tcnt_q  <= '0;
      mcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      cond_q  <= cond_d;
      cbz_q   <= cbz_d;
      cbnz_q  <= cbnz_d;
      rtz_q   <= rtz_d;
      pred_q  <= pred_d;
      taken_q <= taken_d;
      mis_q   <= mis_d;
      tcnt_q  <= tcnt_d;
      mcnt_q  <= mcnt_d;
    end
  end

  assign req_ready      = idle;
  assign res_valid      = state_q == RESP;
  assign res_taken      = taken_q;
  assign res_mispredict = mis_q;
  assign taken_cnt      = tcnt_q;
  assign mispred_cnt    = mcnt_q;
endmodule

// File: tb/tb_cond_resolve_unit.sv
// tb_cond_resolve_unit: directed and randomized checks of cond_resolve_unit against a behavioural model.
module tb_cond_resolve_unit;
  logic clk = 0, reset = 0;
  logic negativeC = 0, zeroC = 0, overflowC = 0, carry_outC = 0;
  logic fwd_en = 0, fwd_n = 0, fwd_z = 0, fwd_v = 0, fwd_c = 0, flags_pending = 0;
  logic req_valid = 0, req_ready, req_is_cbz = 0, req_cbnz = 0, req_rt_zero = 0, req_pred = 0;
  logic [3:0] req_cond = 0;
  logic res_valid, res_ready = 0, res_taken, res_mispredict;
  logic [3:0] taken_cnt, mispred_cnt;
  int total = 0, bad = 0, exp_t = 0, exp_m = 0;

  cond_resolve_unit #(.CNT_W(4)) dut (
    .clk(clk), .reset(reset), .negativeC(negativeC), .zeroC(zeroC), .overflowC(overflowC),
    .carry_outC(carry_outC), .fwd_en(fwd_en), .fwd_n(fwd_n), .fwd_z(fwd_z), .fwd_v(fwd_v),
    .fwd_c(fwd_c), .flags_pending(flags_pending), .req_valid(req_valid), .req_ready(req_ready),
    .req_cond(req_cond), .req_is_cbz(req_is_cbz), .req_cbnz(req_cbnz), .req_rt_zero(req_rt_zero),
    .req_pred(req_pred), .res_valid(res_valid), .res_ready(res_ready), .res_taken(res_taken),
    .res_mispredict(res_mispredict), .taken_cnt(taken_cnt), .mispred_cnt(mispred_cnt)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Conditions come in complementary pairs; bit 0 inverts, except the AL/NV pair.
  function automatic bit model_cond(input logic [3:0] cc, input bit n, z, v, c);
    bit b;
    case (cc >> 1)
      0: b = z;
      1: b = c;
      2: b = n;
      3: b = v;
      4: b = c & ~z;
      5: b = n ~^ v;
      6: b = ~z & (n ~^ v);
      default: return 1'b1;
    endcase
    return b ^ cc[0];
  endfunction

  function automatic bit model_now();
    if (req_is_cbz) return req_rt_zero ^ req_cbnz;
    if (fwd_en) return model_cond(req_cond, fwd_n, fwd_z, fwd_v, fwd_c);
    return model_cond(req_cond, negativeC, zeroC, overflowC, carry_outC);
  endfunction

  function automatic int sat(input int v, input bit inc);
    return (inc && v < 15) ? v + 1 : v;
  endfunction

  task automatic test_reset();
    reset = 0;
    tick();
    tick();
    total++; if (res_valid !== 1'b0) begin bad++; $display("FAIL reset_valid: got %b want 0", res_valid); end
    total++; if (req_ready !== 1'b1) begin bad++; $display("FAIL reset_ready: got %b want 1", req_ready); end
    total++; if ({res_taken, res_mispredict} !== 2'b00) begin bad++; $display("FAIL reset_res: got %b want 00", {res_taken, res_mispredict}); end
    total++; if ({taken_cnt, mispred_cnt} !== 8'h00) begin bad++; $display("FAIL reset_cnt: got %h want 00", {taken_cnt, mispred_cnt}); end
    exp_t = 0;
    exp_m = 0;
    reset = 1;
  endtask

  task automatic test_eq_stored();
    {negativeC, zeroC, overflowC, carry_outC} = 4'b0100;
    fwd_en = 0;
    req_valid = 1; req_is_cbz = 0; req_cond = 4'd0; req_pred = 0;
    tick();
    req_valid = 0;
    total++; if ({res_valid, res_taken, res_mispredict} !== 3'b111) begin bad++; $display("FAIL eq_result: got %b want 111", {res_valid, res_taken, res_mispredict}); end
    res_ready = 1;
    tick();
    res_ready = 0;
    total++; if (res_valid !== 1'b0) begin bad++; $display("FAIL eq_handoff: got %b want 0", res_valid); end
    total++; if ({taken_cnt, mispred_cnt} !== 8'h11) begin bad++; $display("FAIL eq_cnt: got %h want 11", {taken_cnt, mispred_cnt}); end
    exp_t = 1;
    exp_m = 1;
  endtask

  task automatic test_forward();
    {negativeC, zeroC, overflowC, carry_outC} = 4'b0000;
    fwd_en = 1; {fwd_n, fwd_z, fwd_v, fwd_c} = 4'b1000;
    req_valid = 1; req_cond = 4'd11; req_pred = 1;
    tick();
    req_valid = 0; fwd_en = 0;
    total++; if ({res_valid, res_taken, res_mispredict} !== 3'b110) begin bad++; $display("FAIL fwd_lt: got %b want 110", {res_valid, res_taken, res_mispredict}); end
    res_ready = 1;
    tick();
    res_ready = 0;
    exp_t = sat(exp_t, 1);
    total++; if (taken_cnt !== 4'(exp_t)) begin bad++; $display("FAIL fwd_cnt: got %0d want %0d", taken_cnt, exp_t); end
  endtask

  task automatic test_wait();
    {negativeC, zeroC, overflowC, carry_outC} = 4'b0100;
    flags_pending = 1;
    req_valid = 1; req_cond = 4'd12; req_pred = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      req_valid = (i == 0) ? 1'b1 : 1'b0;
      fwd_en = (i == 1);
      {fwd_n, fwd_z, fwd_v, fwd_c} = 4'b1010;
      total++; if ({req_ready, res_valid} !== 2'b00) begin bad++; $display("FAIL wait_hold%0d: got %b want 00", i, {req_ready, res_valid}); end
    end
    req_valid = 0;
    fwd_en = 0;
    flags_pending = 0;
    {negativeC, zeroC, overflowC, carry_outC} = 4'b1010;
    tick();
    total++; if ({res_valid, res_taken, res_mispredict, req_ready} !== 4'b1110) begin bad++; $display("FAIL wait_gt: got %b want 1110", {res_valid, res_taken, res_mispredict, req_ready}); end
    res_ready = 1;
    tick();
    res_ready = 0;
    exp_t = sat(exp_t, 1);
    exp_m = sat(exp_m, 1);
    total++; if ({taken_cnt, mispred_cnt} !== {4'(exp_t), 4'(exp_m)}) begin bad++; $display("FAIL wait_cnt: got %h want %h", {taken_cnt, mispred_cnt}, {4'(exp_t), 4'(exp_m)}); end
  endtask

  task automatic test_cbz();
    flags_pending = 1;
    req_valid = 1; req_is_cbz = 1; req_cbnz = 1; req_rt_zero = 1; req_pred = 1; req_cond = 4'd0;
    tick();
    req_valid = 0;
    total++; if ({res_valid, res_taken, res_mispredict} !== 3'b101) begin bad++; $display("FAIL cbnz: got %b want 101", {res_valid, res_taken, res_mispredict}); end
    res_ready = 1;
    tick();
    res_ready = 0;
    exp_m = sat(exp_m, 1);
    req_valid = 1; req_cbnz = 0;
    tick();
    req_valid = 0;
    total++; if ({res_valid, res_taken, res_mispredict} !== 3'b110) begin bad++; $display("FAIL cbz: got %b want 110", {res_valid, res_taken, res_mispredict}); end
    res_ready = 1;
    tick();
    res_ready = 0;
    exp_t = sat(exp_t, 1);
    req_is_cbz = 0;
    flags_pending = 0;
    total++; if ({taken_cnt, mispred_cnt} !== {4'(exp_t), 4'(exp_m)}) begin bad++; $display("FAIL cbz_cnt: got %h want %h", {taken_cnt, mispred_cnt}, {4'(exp_t), 4'(exp_m)}); end
  endtask

  task automatic test_backpressure();
    req_valid = 1; req_cond = 4'd14; req_pred = 0;
    tick();
    for (int i = 0; i < 5; i++) begin
      req_valid = i[0];
      req_cond = 4'($urandom);
      req_pred = 1;
      {negativeC, zeroC, overflowC, carry_outC} = 4'($urandom);
      tick();
      total++; if ({res_valid, res_taken, res_mispredict, req_ready} !== 4'b1110) begin bad++; $display("FAIL bp_hold%0d: got %b want 1110", i, {res_valid, res_taken, res_mispredict, req_ready}); end
      total++; if ({taken_cnt, mispred_cnt} !== {4'(exp_t), 4'(exp_m)}) begin bad++; $display("FAIL bp_cnt%0d: got %h want %h", i, {taken_cnt, mispred_cnt}, {4'(exp_t), 4'(exp_m)}); end
    end
    req_valid = 0;
    res_ready = 1;
    tick();
    res_ready = 0;
    exp_t = sat(exp_t, 1);
    exp_m = sat(exp_m, 1);
    total++; if ({res_valid, taken_cnt, mispred_cnt} !== {1'b0, 4'(exp_t), 4'(exp_m)}) begin bad++; $display("FAIL bp_handoff: got %h want %h", {res_valid, taken_cnt, mispred_cnt}, {1'b0, 4'(exp_t), 4'(exp_m)}); end
  endtask

  task automatic test_random();
    bit et, em;
    for (int it = 0; it < 60; it++) begin
      {negativeC, zeroC, overflowC, carry_outC, fwd_n, fwd_z, fwd_v, fwd_c, fwd_en} = 9'($urandom);
      req_cond = 4'($urandom);
      req_is_cbz = ($urandom_range(0, 3) == 0);
      {req_cbnz, req_rt_zero, req_pred, flags_pending} = 4'($urandom);
      req_valid = 1;
      if (!req_is_cbz && flags_pending) begin
        tick();
        req_valid = 0;
        for (int k = $urandom_range(0, 2); k > 0; k--) begin
          {negativeC, zeroC, overflowC, carry_outC, fwd_n, fwd_z, fwd_v, fwd_c, fwd_en} = 9'($urandom);
          tick();
          total++; if (res_valid !== 1'b0) begin bad++; $display("FAIL rnd_wait%0d: got %b want 0", it, res_valid); end
        end
        {negativeC, zeroC, overflowC, carry_outC, fwd_n, fwd_z, fwd_v, fwd_c, fwd_en} = 9'($urandom);
        flags_pending = 0;
      end
      et = model_now();
      em = et ^ req_pred;
      tick();
      req_valid = 0;
      flags_pending = 0;
      for (int k = $urandom_range(0, 2); k >= 0; k--) begin
        {negativeC, zeroC, overflowC, carry_outC} = 4'($urandom);
        total++; if ({res_valid, res_taken, res_mispredict} !== {1'b1, et, em}) begin bad++; $display("FAIL rnd_res%0d: got %b want %b", it, {res_valid, res_taken, res_mispredict}, {1'b1, et, em}); end
        if (k > 0) tick();
      end
      res_ready = 1;
      tick();
      res_ready = 0;
      exp_t = sat(exp_t, et);
      exp_m = sat(exp_m, em);
      total++; if ({taken_cnt, mispred_cnt} !== {4'(exp_t), 4'(exp_m)}) begin bad++; $display("FAIL rnd_cnt%0d: got %h want %h", it, {taken_cnt, mispred_cnt}, {4'(exp_t), 4'(exp_m)}); end
    end
  endtask

  task automatic test_saturation();
    test_reset();
    req_is_cbz = 0; req_cond = 4'd14; req_pred = 1; flags_pending = 0;
    for (int i = 0; i < 16; i++) begin
      req_valid = 1;
      tick();
      req_valid = 0;
      res_ready = 1;
      tick();
      res_ready = 0;
      exp_t = sat(exp_t, 1);
    end
    total++; if ({taken_cnt, mispred_cnt} !== 8'hF0) begin bad++; $display("FAIL sat_cnt: got %h want f0", {taken_cnt, mispred_cnt}); end
    total++; if (taken_cnt !== 4'(exp_t)) begin bad++; $display("FAIL sat_model: got %0d want %0d", taken_cnt, exp_t); end
  endtask

  task automatic test_reset_midwait();
    flags_pending = 1;
    req_valid = 1; req_is_cbz = 0; req_cond = 4'd0;
    tick();
    req_valid = 0;
    total++; if ({req_ready, res_valid} !== 2'b00) begin bad++; $display("FAIL mw_inwait: got %b want 00", {req_ready, res_valid}); end
    reset = 0;
    tick();
    reset = 1;
    total++; if ({req_ready, res_valid, taken_cnt, mispred_cnt} !== 10'b10_0000_0000) begin bad++; $display("FAIL mw_reset: got %b want 1000000000", {req_ready, res_valid, taken_cnt, mispred_cnt}); end
    flags_pending = 0;
    tick();
    total++; if ({req_ready, res_valid} !== 2'b10) begin bad++; $display("FAIL mw_discard: got %b want 10", {req_ready, res_valid}); end
  endtask

  initial begin
    test_reset();
    test_eq_stored();
    test_forward();
    test_wait();
    test_cbz();
    test_backpressure();
    test_random();
    test_saturation();
    test_reset_midwait();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
